// File: rtl/multi_strand_ifetch_pkg.sv
// rtl/multi_strand_ifetch_pkg.sv - shared constants and helpers for the multi-strand fetch stage
package ifetch_pkg;

    localparam int INSTR_WIDTH = 32;

    // Pointer width for a power-of-two FIFO; occupancy needs one extra bit
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width of the round-robin start pointer; a single strand still needs one bit
    function automatic int rr_width(input int num_strands);
        return (num_strands > 1) ? $clog2(num_strands) : 1;
    endfunction

    // Cache words arrive little-endian; the decoder wants the bytes reversed
    function automatic logic [INSTR_WIDTH-1:0] byte_swap(input logic [INSTR_WIDTH-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/multi_strand_ifetch_fifo.sv
// rtl/multi_strand_ifetch_fifo.sv - per-strand instruction FIFO with flush and occupancy
module strand_fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PW = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_enqueue,
    input  logic             i_dequeue,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [PW:0]      o_occupancy
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push      = i_enqueue & (r_count != (PW+1)'(DEPTH));
    assign w_pop       = i_dequeue & (r_count != '0);
    assign o_data      = r_mem[r_rd_ptr];
    assign o_empty     = (r_count == '0);
    assign o_occupancy = r_count;

    // Pointer and count update; a flush wins over any simultaneous push or pop
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/multi_strand_ifetch.sv
// rtl/multi_strand_ifetch.sv - round-robin multi-strand fetch stage; IFETCH_MISS_STATS_EN adds miss counters
module multi_strand_ifetch
    import ifetch_pkg::*;
#(
    parameter int                    NUM_STRANDS = 4,
    parameter int                    FIFO_DEPTH  = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [ADDR_WIDTH-1:0]             iaddress_o,
    output logic                              iaccess_o,
    input  logic [INSTR_WIDTH-1:0]            idata_i,
    input  logic                              icache_hit_i,
    output logic [NUM_STRANDS*INSTR_WIDTH-1:0] instruction_o,
    output logic [NUM_STRANDS*ADDR_WIDTH-1:0] pc_o,
    output logic [NUM_STRANDS-1:0]            instruction_ack_o,
    input  logic [NUM_STRANDS-1:0]            instruction_request_i,
    input  logic [NUM_STRANDS-1:0]            restart_request_i,
    input  logic [NUM_STRANDS*ADDR_WIDTH-1:0] restart_address_i
`ifdef IFETCH_MISS_STATS_EN
    ,
    output logic [NUM_STRANDS*16-1:0]         miss_count_o
`endif
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam int RW = rr_width(NUM_STRANDS);
    localparam int DW = ADDR_WIDTH + INSTR_WIDTH;

    logic [ADDR_WIDTH-1:0]  r_pc       [NUM_STRANDS];
    logic [ADDR_WIDTH-1:0]  w_pc_nxt   [NUM_STRANDS];
    logic [OW-1:0]          w_occ      [NUM_STRANDS];
    logic [DW-1:0]          w_head     [NUM_STRANDS];
    logic [NUM_STRANDS-1:0] r_grant;
    logic [NUM_STRANDS-1:0] w_grant;
    logic [NUM_STRANDS-1:0] w_eligible;
    logic [NUM_STRANDS-1:0] w_enqueue;
    logic [NUM_STRANDS-1:0] w_dequeue;
    logic [NUM_STRANDS-1:0] w_empty;
    logic [RW-1:0]          r_rr_ptr;
    logic [RW-1:0]          w_rr_nxt;
    logic [RW-1:0]          w_idx;
    logic                   w_any_grant;
    logic [INSTR_WIDTH-1:0] w_swapped;

    assign w_swapped = byte_swap(idata_i);
    assign iaccess_o = |w_eligible;

    // Per-strand response handling, next PC and credit-based eligibility
    always_comb begin
        for (int s = 0; s < NUM_STRANDS; s++) begin
            w_enqueue[s] = r_grant[s] & icache_hit_i & ~restart_request_i[s];
            w_dequeue[s] = instruction_request_i[s] & ~w_empty[s];
            if (restart_request_i[s])
                w_pc_nxt[s] = restart_address_i[s*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
            else if (w_enqueue[s])
                w_pc_nxt[s] = r_pc[s] + ADDR_WIDTH'(4);
            else
                w_pc_nxt[s] = r_pc[s];
            w_eligible[s] = ((w_occ[s] + OW'(r_grant[s])) < OW'(FIFO_DEPTH)) & ~restart_request_i[s];
        end
    end

    // Rotating-priority arbiter starting one past the last granted strand
    always_comb begin
        w_grant     = '0;
        w_any_grant = 1'b0;
        w_rr_nxt    = r_rr_ptr;
        w_idx       = '0;
        for (int i = 0; i < NUM_STRANDS; i++) begin
            w_idx = RW'((int'(r_rr_ptr) + i) % NUM_STRANDS);
            if (!w_any_grant && w_eligible[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_any_grant    = 1'b1;
                w_rr_nxt       = RW'((int'(w_idx) + 1) % NUM_STRANDS);
            end
        end
    end

    // Fetch address is the granted strand's next PC, zero when idle
    always_comb begin
        iaddress_o = '0;
        for (int s = 0; s < NUM_STRANDS; s++) begin
            if (w_grant[s]) iaddress_o = w_pc_nxt[s];
        end
    end

    // PC, in-flight grant and arbitration pointer state
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STRANDS; s++) r_pc[s] <= RESET_PC;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            for (int s = 0; s < NUM_STRANDS; s++) r_pc[s] <= w_pc_nxt[s];
            r_grant  <= w_grant;
            if (w_any_grant) r_rr_ptr <= w_rr_nxt;
        end
    end

    for (genvar g = 0; g < NUM_STRANDS; g++) begin : g_strand
        strand_fetch_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (DW)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .i_flush     (restart_request_i[g]),
            .i_enqueue   (w_enqueue[g]),
            .i_dequeue   (w_dequeue[g]),
            .i_data      ({r_pc[g], w_swapped}),
            .o_data      (w_head[g]),
            .o_empty     (w_empty[g]),
            .o_occupancy (w_occ[g])
        );
        assign instruction_o[g*INSTR_WIDTH +: INSTR_WIDTH] = w_head[g][INSTR_WIDTH-1:0];
        assign pc_o[g*ADDR_WIDTH +: ADDR_WIDTH]            = w_head[g][DW-1 -: ADDR_WIDTH];
        assign instruction_ack_o[g]                        = ~w_empty[g];
    end

`ifdef IFETCH_MISS_STATS_EN
    logic [15:0] r_miss_cnt [NUM_STRANDS];

    // Saturating per-strand miss counters; restarted strands do not count
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_STRANDS; s++) begin
            if (reset)
                r_miss_cnt[s] <= '0;
            else if (r_grant[s] && !icache_hit_i && !restart_request_i[s] && (r_miss_cnt[s] != 16'hFFFF))
                r_miss_cnt[s] <= r_miss_cnt[s] + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_STRANDS; g++) begin : g_miss
        assign miss_count_o[g*16 +: 16] = r_miss_cnt[g];
    end
`endif

endmodule

// File: tb/tb_multi_strand_ifetch.sv
// tb/tb_multi_strand_ifetch.sv - randomized bench for multi_strand_ifetch against a queue-based reference model
module tb_multi_strand_ifetch;

    localparam int              NS    = 4;
    localparam int              DEPTH = 4;
    localparam int              AW    = 32;
    localparam logic [AW-1:0]   RPC   = 32'h0;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     iaddress_o;
    logic              iaccess_o;
    logic [31:0]       idata_i;
    logic              icache_hit_i;
    logic [NS*32-1:0]  instruction_o;
    logic [NS*AW-1:0]  pc_o;
    logic [NS-1:0]     instruction_ack_o;
    logic [NS-1:0]     instruction_request_i;
    logic [NS-1:0]     restart_request_i;
    logic [NS*AW-1:0]  restart_address_i;
`ifdef IFETCH_MISS_STATS_EN
    logic [NS*16-1:0]  miss_count_o;
`endif

    multi_strand_ifetch #(
        .NUM_STRANDS (NS),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_WIDTH  (AW),
        .RESET_PC    (RPC)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .iaddress_o            (iaddress_o),
        .iaccess_o             (iaccess_o),
        .idata_i               (idata_i),
        .icache_hit_i          (icache_hit_i),
        .instruction_o         (instruction_o),
        .pc_o                  (pc_o),
        .instruction_ack_o     (instruction_ack_o),
        .instruction_request_i (instruction_request_i),
        .restart_request_i     (restart_request_i),
        .restart_address_i     (restart_address_i)
`ifdef IFETCH_MISS_STATS_EN
        ,
        .miss_count_o          (miss_count_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: PC per strand, FIFO contents as queues, one pending request
    logic [AW-1:0]    m_pc   [NS];
    logic [AW+31:0]   m_q    [NS][$];
    int               m_miss [NS];
    int               m_pend;
    int               m_rr;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {<<8{w}};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_pc[s] = RPC;
            m_q[s].delete();
            m_miss[s] = 0;
        end
        m_pend = -1;
        m_rr   = 0;
    endtask

    task automatic cycle(input bit rst_glb, input logic h, input logic [31:0] d,
                         input logic [NS-1:0] req, input logic [NS-1:0] rr,
                         input logic [NS*AW-1:0] ra);
        logic [AW-1:0]  pn [NS];
        logic [NS-1:0]  elig;
        logic [NS-1:0]  ack;
        logic [AW+31:0] head;
        logic [AW-1:0]  ea;
        int             g;
        int             s;
        @(negedge clk);
        reset                 = rst_glb;
        icache_hit_i          = h;
        idata_i               = d;
        instruction_request_i = req;
        restart_request_i     = rr;
        restart_address_i     = ra;
        #1;
        if (rst_glb) begin
            model_reset();
            return;
        end
        g    = -1;
        elig = '0;
        ack  = '0;
        for (int k = 0; k < NS; k++) begin
            if (rr[k])                  pn[k] = ra[k*AW +: AW] & ~AW'(3);
            else if (m_pend == k && h)  pn[k] = m_pc[k] + AW'(4);
            else                        pn[k] = m_pc[k];
            elig[k] = (m_q[k].size() + ((m_pend == k) ? 1 : 0) < DEPTH) && !rr[k];
            ack[k]  = (m_q[k].size() != 0);
        end
        for (int i = 0; i < NS; i++) begin
            s = (m_rr + i) % NS;
            if (g < 0 && elig[s]) g = s;
        end
        ea = (g >= 0) ? pn[g] : '0;
        check("iaccess", 64'(iaccess_o), 64'(|elig));
        check("iaddress", 64'(iaddress_o), 64'(ea));
        check("ack", 64'(instruction_ack_o), 64'(ack));
        for (int k = 0; k < NS; k++) begin
            if (m_q[k].size() != 0) begin
                head = m_q[k][0];
                check($sformatf("instr%0d", k), 64'(instruction_o[k*32 +: 32]), 64'(head[31:0]));
                check($sformatf("pc%0d", k), 64'(pc_o[k*AW +: AW]), 64'(head[AW+31:32]));
            end
`ifdef IFETCH_MISS_STATS_EN
            check($sformatf("miss%0d", k), 64'(miss_count_o[k*16 +: 16]), 64'(m_miss[k]));
`endif
        end
        for (int k = 0; k < NS; k++) begin
            if (m_pend == k && !h && !rr[k] && m_miss[k] < 65535) m_miss[k]++;
            if (rr[k]) begin
                m_q[k].delete();
            end else begin
                if (req[k] && m_q[k].size() != 0) void'(m_q[k].pop_front());
                if (m_pend == k && h) m_q[k].push_back({m_pc[k], swap32(d)});
            end
            m_pc[k] = pn[k];
        end
        m_pend = g;
        if (g >= 0) m_rr = (g + 1) % NS;
    endtask

    task automatic post_reset_check();
        check("rst_iaccess", 64'(iaccess_o), 64'(1));
        check("rst_ack", 64'(instruction_ack_o), 64'(0));
        check("rst_iaddress", 64'(iaddress_o), 64'(RPC));
    endtask

    logic [AW-1:0]    prev_pc;
    logic [NS*AW-1:0] ra_r;
    logic [NS-1:0]    rr_r;
    bit               rst_r;

    initial begin
        reset                 = 1'b1;
        icache_hit_i          = 1'b0;
        idata_i               = '0;
        instruction_request_i = '0;
        restart_request_i     = '0;
        restart_address_i     = '0;
        model_reset();

        // Fill all FIFOs with hits and no consumer
        cycle(1, 0, 0, '0, '0, '0);
        cycle(1, 0, 0, '0, '0, '0);
        cycle(0, 1, 32'h11223344, '0, '0, '0);
        post_reset_check();
        repeat (19) cycle(0, 1, 32'h11223344, '0, '0, '0);
        check("fill_iaccess", 64'(iaccess_o), 64'(0));
        check("fill_ack", 64'(instruction_ack_o), 64'(4'hF));
        check("fill_swap", 64'(instruction_o[31:0]), 64'(32'h44332211));
        check("fill_pc3", 64'(pc_o[3*AW +: AW]), 64'(0));

        // Strand 1 alone: miss at PC 8 is retried at the same address
        cycle(1, 0, 0, '0, '0, '0);
        cycle(0, 1, 32'h0, '0, 4'b1101, '0);
        cycle(0, 1, 32'h0, '0, 4'b1101, '0);
        cycle(0, 1, 32'h0, '0, 4'b1101, '0);
        cycle(0, 0, 32'h0, '0, 4'b1101, '0);
        check("retry_addr", 64'(iaddress_o), 64'(32'h8));
        cycle(0, 1, 32'h11223344, '0, 4'b1101, '0);
        check("after_retry_addr", 64'(iaddress_o), 64'(32'hC));
        repeat (4) cycle(0, 1, 32'h0, '0, '0, '0);

        // Restart on strand 2 in the cycle its response arrives
        cycle(1, 0, 0, '0, '0, '0);
        repeat (3) cycle(0, 1, $urandom, '0, '0, '0);
        ra_r = '0;
        ra_r[2*AW +: AW] = 32'h1003;
        cycle(0, 1, $urandom, '0, 4'b0100, ra_r);
        cycle(0, 1, $urandom, '0, '0, '0);
        check("restart_ack2", 64'(instruction_ack_o[2]), 64'(0));
        check("restart_ack01", 64'(instruction_ack_o[1:0]), 64'(2'b11));
        repeat (6) cycle(0, 1, $urandom, '0, '0, '0);

        // Single strand streaming with continuous dequeue
        cycle(1, 0, 0, '0, '0, '0);
        prev_pc = '0;
        for (int c = 0; c < 24; c++) begin
            cycle(0, 1, $urandom, 4'b0001, 4'b1110, '0);
            if (c >= 2) begin
                check("stream_ack", 64'(instruction_ack_o[0]), 64'(1));
                check("stream_iaccess", 64'(iaccess_o), 64'(1));
            end
            if (c >= 3) check("stream_pc", 64'(pc_o[AW-1:0]), 64'(prev_pc + AW'(4)));
            prev_pc = pc_o[AW-1:0];
        end

        // Reset while a response is in flight
        repeat (7) cycle(0, 1, $urandom, NS'($urandom), '0, '0);
        cycle(0, 1, $urandom, '0, '0, '0);
        cycle(1, 1, $urandom, '0, '0, '0);
        cycle(0, 1, $urandom, '0, '0, '0);
        post_reset_check();

        // Random traffic with occasional restarts and resets
        for (int c = 0; c < 3000; c++) begin
            rst_r = ($urandom_range(0, 199) == 0);
            rr_r  = NS'($urandom & $urandom & $urandom & $urandom);
            ra_r  = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 49) == 0) ra_r[AW-1:0] = 32'hFFFF_FFFC;
            cycle(rst_r, ($urandom_range(0, 9) < 8), $urandom, NS'($urandom), rr_r, ra_r);
        end

`ifdef IFETCH_MISS_STATS_EN
        // Three misses on strand 3, then saturation under continuous misses
        cycle(1, 0, 0, '0, '0, '0);
        cycle(0, 0, 0, '0, 4'b0111, '0);
        repeat (3) cycle(0, 0, 0, '0, 4'b0111, '0);
        cycle(0, 1, 0, '0, 4'b0111, '0);
        check("miss3", 64'(miss_count_o), {16'd3, 48'd0});
        repeat (65540) cycle(0, 0, 0, '0, 4'b0111, '0);
        check("miss_sat", 64'(miss_count_o[63:48]), 64'(16'hFFFF));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
